// File: rtl/thruster_array_if.sv
// Command port of the thruster array: one valid/ready command per cycle.
interface thruster_array_if #(
    parameter int unsigned CHW = 2,
    parameter int unsigned TW  = 9,
    parameter int unsigned DW  = 8
) ();
    logic           cmd_valid;
    logic           cmd_ready;
    logic [CHW-1:0] cmd_ch;
    logic [1:0]     cmd_op;
    logic [TW-1:0]  cmd_thrust;
    logic [DW-1:0]  cmd_dur;

    modport master (output cmd_valid, cmd_ch, cmd_op, cmd_thrust, cmd_dur,
                    input  cmd_ready);
    modport slave  (input  cmd_valid, cmd_ch, cmd_op, cmd_thrust, cmd_dur,
                    output cmd_ready);
endinterface

// File: rtl/thruster_array.sv
// Multi-axis reaction-thruster controller: per-channel burn/brake/abort FSM
// integrating saturated signed velocity into a wrapping angle.
module thruster_array #(
    parameter int unsigned CH   = 3,
    parameter int unsigned CHW  = 2,
    parameter int unsigned W    = 9,
    parameter int unsigned TW   = 9,
    parameter int unsigned DW   = 8,
    parameter int unsigned NPR  = 100,
    parameter int unsigned VMAX = 255
) (
    input  logic               clk,
    input  logic               rst,
    thruster_array_if.slave    cmd,
    output logic [CH*W-1:0]    velocity,
    output logic [CH*W-1:0]    angle,
    output logic [CH-1:0]      busy,
    output logic [CH-1:0]      done,
    output logic [CH-1:0]      sat,
    output logic               err
);
    typedef enum logic [1:0] {S_IDLE, S_BURN, S_BRAKE} state_t;

    localparam logic [1:0] OP_CCW   = 2'b01;
    localparam logic [1:0] OP_BRAKE = 2'b10;
    localparam logic [1:0] OP_ABORT = 2'b11;
    // Extended width so sign/saturation arithmetic never wraps
    localparam int unsigned XW = ((W > TW) ? W : TW) + 2;
    localparam logic signed [XW-1:0] VPOS = XW'(VMAX);
    localparam logic signed [XW-1:0] VNEG = -VPOS;

    logic [CH-1:0] idle;
    logic          ch_ok;
    logic          ready_c;
    logic          accept;
    logic          err_q;

    // Ready: aborts and out-of-range channels always accepted, else target must be idle
    always_comb begin
        ch_ok   = {1'b0, cmd.cmd_ch} < (CHW+1)'(CH);
        ready_c = (cmd.cmd_op == OP_ABORT) || !ch_ok;
        for (int c = 0; c < CH; c++) begin
            if (cmd.cmd_ch == CHW'(c) && idle[c]) ready_c = 1'b1;
        end
    end

    assign cmd.cmd_ready = ready_c;
    assign accept        = cmd.cmd_valid && ready_c;
    assign err           = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= accept && !ch_ok;
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        state_t                state_q, state_d;
        logic signed [W-1:0]   vel_q, vel_d;
        logic [W-1:0]          ang_q, ang_d;
        logic [TW-1:0]         delta_q, delta_d;
        logic [DW-1:0]         rem_q, rem_d;
        logic                  dir_q, dir_d;
        logic                  sat_q, sat_d;
        logic                  done_q, done_d;
        logic                  busy_q;
        logic                  hit;
        logic signed [XW-1:0]  vx, dx, sum, mag;

        assign hit = accept && (cmd.cmd_ch == CHW'(g));

        always_comb begin
            state_d = state_q;
            vel_d   = vel_q;
            delta_d = delta_q;
            rem_d   = rem_q;
            dir_d   = dir_q;
            sat_d   = sat_q;
            done_d  = 1'b0;
            vx      = XW'(vel_q);
            dx      = XW'(delta_q);
            sum     = vx;
            mag     = (vx < 0) ? -vx : vx;
            unique case (state_q)
                S_BURN: begin
                    sum = dir_q ? (vx - dx) : (vx + dx);
                    if (sum > VPOS) begin
                        sum   = VPOS;
                        sat_d = 1'b1;
                    end else if (sum < VNEG) begin
                        sum   = VNEG;
                        sat_d = 1'b1;
                    end
                    vel_d = W'(sum);
                    rem_d = rem_q - DW'(1);
                    if (rem_q == DW'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                S_BRAKE: begin
                    if (dx == '0) dx = XW'(1);
                    // Step toward zero, snapping to zero instead of overshooting
                    if (mag <= dx) begin
                        sum     = '0;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        sum = (vx < 0) ? (vx + dx) : (vx - dx);
                    end
                    vel_d = W'(sum);
                end
                default: ;
            endcase
            if (hit) begin
                sat_d   = 1'b0;
                delta_d = TW'(cmd.cmd_thrust / TW'(NPR));
                if (cmd.cmd_op == OP_ABORT) begin
                    state_d = S_IDLE;
                    vel_d   = vel_q;
                    done_d  = 1'b0;
                end else begin
                    state_d = (cmd.cmd_op == OP_BRAKE) ? S_BRAKE : S_BURN;
                    dir_d   = (cmd.cmd_op == OP_CCW);
                    rem_d   = (cmd.cmd_dur == '0) ? DW'(1) : cmd.cmd_dur;
                end
            end
            ang_d = ang_q + $unsigned(vel_d);
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= S_IDLE;
                vel_q   <= '0;
                ang_q   <= '0;
                delta_q <= '0;
                rem_q   <= '0;
                dir_q   <= 1'b0;
                sat_q   <= 1'b0;
                done_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                vel_q   <= vel_d;
                ang_q   <= ang_d;
                delta_q <= delta_d;
                rem_q   <= rem_d;
                dir_q   <= dir_d;
                sat_q   <= sat_d;
                done_q  <= done_d;
                busy_q  <= (state_d != S_IDLE);
            end
        end

        assign idle[g]              = (state_q == S_IDLE);
        assign velocity[g*W +: W]   = vel_q;
        assign angle[g*W +: W]      = ang_q;
        assign busy[g]              = busy_q;
        assign done[g]              = done_q;
        assign sat[g]               = sat_q;
    end
endmodule
